aes_spi_responder: RTL

SPI responder front-end for the AES cores. Oversamples `cs_n`/`sclk`/`sdi` in the system clock domain and deserializes three-frame transactions: key (with 2-bit size header), 128-bit data block, and a read frame on which it shifts the core's 128-bit result back out on `sdo`. It sits between the SPI pins and the AES encrypt/decrypt datapath and implements the responder end of the link driven by `SPI_Main`.

---
 rtl/aes_spi_pkg.sv | 49 ++++
 rtl/spi_in_sync.sv | 47 ++++
 rtl/aes_spi_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/aes_spi_pkg.sv
// Shared codes, frame lengths and state types for the AES SPI responder.
// Frames are a 2-bit header followed by a 128/192/256-bit payload.
package aes_spi_pkg;

  localparam int unsigned FRAME_W = 258;
  localparam int unsigned TX_W    = 130;

  localparam logic [8:0] LEN_128 = 9'd130;
  localparam logic [8:0] LEN_192 = 9'd194;
  localparam logic [8:0] LEN_256 = 9'd258;
  // One past the longest legal frame: marks an overlong frame and stops counting.
  localparam logic [8:0] CNT_SAT = 9'd259;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10
  } key_len_e;

  typedef enum logic [1:0] {
    PH_KEY,
    PH_MSG,
    PH_READ
  } phase_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } frame_e;

  // Single-cycle strobes and data bit, all aligned to the same synced clk cycle.
  typedef struct packed {
    logic cs_fall;
    logic cs_rise;
    logic sclk_rise;
    logic sclk_fall;
    logic sdi;
  } pin_ev_t;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_KEY:  return PH_MSG;
      PH_MSG:  return PH_READ;
      default: return PH_KEY;
    endcase
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Synchronizes the SPI pins into clk and produces registered edge strobes.
// Strobes appear SYNC_STAGES+1 clk after the pin edge; SYNC_STAGES must be >= 2.
module spi_in_sync
  import aes_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cs_n,
  input  logic    sclk,
  input  logic    sdi,
  output pin_ev_t ev
);

  logic [SYNC_STAGES-1:0] cs_q, sclk_q, sdi_q;
  logic                   cs_d, sclk_d;
  logic                   cs_s, sclk_s;

  assign cs_s   = cs_q[SYNC_STAGES-1];
  assign sclk_s = sclk_q[SYNC_STAGES-1];

  // cs chain resets low: a frame already in progress when reset releases
  // never produces a fall strobe, so only a fresh cs_n fall starts a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q   <= '0;
      sclk_q <= '0;
      sdi_q  <= '0;
      cs_d   <= 1'b0;
      sclk_d <= 1'b0;
      ev     <= '0;
    end else begin
      cs_q         <= {cs_q[SYNC_STAGES-2:0], cs_n};
      sclk_q       <= {sclk_q[SYNC_STAGES-2:0], sclk};
      sdi_q        <= {sdi_q[SYNC_STAGES-2:0], sdi};
      cs_d         <= cs_s;
      sclk_d       <= sclk_s;
      ev.cs_fall   <= cs_d & ~cs_s;
      ev.cs_rise   <= ~cs_d & cs_s;
      ev.sclk_rise <= ~sclk_d & sclk_s;
      ev.sclk_fall <= sclk_d & ~sclk_s;
      ev.sdi       <= sdi_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/aes_spi_responder.sv
// SPI mode-0 responder: key frame, data frame, then a read frame that returns
// the AES result. A frame only takes effect if its header and length are legal.
module aes_spi_responder
  import aes_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cs_n,
  input  logic         sclk,
  input  logic         sdi,
  output logic         sdo,
  output logic [255:0] key,
  output logic [1:0]   key_len,
  output logic         key_valid,
  output logic [127:0] msg,
  output logic         msg_valid,
  input  logic [127:0] res,
  input  logic         res_valid,
  output logic         frame_err
);

  pin_ev_t ev;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .cs_n  (cs_n),
    .sclk  (sclk),
    .sdi   (sdi),
    .ev    (ev)
  );

  frame_e             fst, fst_nx;
  phase_e             ph;
  logic [8:0]         cnt;
  logic [FRAME_W-1:0] rx;
  logic [TX_W-1:0]    tx;
  logic [127:0]       rbuf;
  logic               rfull;
  logic [1:0]         hdr;
  logic               good;
  logic               frame_end;

  assign frame_end = (fst == SHIFT) && ev.cs_rise;
  assign sdo       = tx[TX_W-1];

  // Header sits in the first two bits received, so its position follows the length.
  always_comb begin
    hdr = 2'b11;
    case (cnt)
      LEN_128: hdr = rx[129:128];
      LEN_192: hdr = rx[193:192];
      LEN_256: hdr = rx[257:256];
      default: hdr = 2'b11;
    endcase
    good = 1'b0;
    case (ph)
      PH_KEY:  good = (cnt == LEN_128 && hdr == KL_128) ||
                      (cnt == LEN_192 && hdr == KL_192) ||
                      (cnt == LEN_256 && hdr == KL_256);
      PH_MSG:  good = (cnt == LEN_128) && (hdr == 2'b00);
      PH_READ: good = (cnt == LEN_128);
      default: good = 1'b0;
    endcase
  end

  always_comb begin
    fst_nx = fst;
    case (fst)
      IDLE:    if (ev.cs_fall) fst_nx = SHIFT;
      SHIFT:   if (ev.cs_rise) fst_nx = CHECK;
      CHECK:   fst_nx = IDLE;
      default: fst_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fst <= IDLE;
    else        fst <= fst_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= PH_KEY;
      cnt       <= '0;
      rx        <= '0;
      tx        <= '0;
      key       <= '0;
      key_len   <= KL_128;
      msg       <= '0;
      key_valid <= 1'b0;
      msg_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      msg_valid <= 1'b0;
      frame_err <= 1'b0;
      if (fst == IDLE && ev.cs_fall) begin
        cnt <= '0;
        rx  <= '0;
        // A result arriving on the load cycle wins over the stored buffer.
        if (ph == PH_READ)
          tx <= {2'b00, res_valid ? res : (rfull ? rbuf : 128'h0)};
        else
          tx <= '0;
      end else if (fst == SHIFT) begin
        if (ev.sclk_rise && cnt != CNT_SAT) begin
          cnt <= cnt + 9'd1;
          if (cnt < LEN_256) rx <= {rx[FRAME_W-2:0], ev.sdi};
        end
        if (ev.sclk_fall) tx <= {tx[TX_W-2:0], 1'b0};
        if (ev.cs_rise) begin
          tx <= '0;
          if (good) begin
            ph <= next_phase(ph);
            case (ph)
              PH_KEY: begin
                key_valid <= 1'b1;
                key_len   <= hdr;
                case (cnt)
                  LEN_128: key <= {rx[127:0], 128'h0};
                  LEN_192: key <= {rx[191:0], 64'h0};
                  default: key <= rx[255:0];
                endcase
              end
              PH_MSG: begin
                msg_valid <= 1'b1;
                msg       <= rx[127:0];
              end
              default: ;
            endcase
          end else begin
            frame_err <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rbuf  <= '0;
      rfull <= 1'b0;
    end else begin
      if (frame_end && good && ph == PH_READ) rfull <= 1'b0;
      if (res_valid) begin
        rbuf  <= res;
        rfull <= 1'b1;
      end
    end
  end

endmodule
